// File: rtl/seq_compare_unit.sv
// Registered comparison engine: pairwise EQ/GT/LT/MAX/MIN on a valid/ready stream,
// plus running max/min over a framed sequence with beat count and winning index.
module seq_compare_unit #(
    parameter int WIDTH  = 4,
    parameter int SIGNED = 0,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [2:0]       mode,
    input  logic             last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       flags,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] win_idx
);

    localparam logic [2:0] MODE_EQ   = 3'd0;
    localparam logic [2:0] MODE_GT   = 3'd1;
    localparam logic [2:0] MODE_LT   = 3'd2;
    localparam logic [2:0] MODE_MAX  = 3'd3;
    localparam logic [2:0] MODE_MIN  = 3'd4;
    localparam logic [2:0] MODE_RMAX = 3'd5;
    localparam logic [2:0] MODE_RMIN = 3'd6;

    // Flipping the MSB maps two's complement order onto unsigned order.
    localparam logic [WIDTH-1:0] SIGN_FLIP = (SIGNED != 0) ? {1'b1, {(WIDTH-1){1'b0}}}
                                                           : {WIDTH{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

    function automatic logic ord_gt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return (a ^ SIGN_FLIP) > (b ^ SIGN_FLIP);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + CNT_ONE;
    endfunction

    state_t             state_r, state_nxt_s;
    logic               seq_min_r, seq_min_nxt_s;
    logic [WIDTH-1:0]   acc_r, acc_nxt_s;
    logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
    logic [CNT_W-1:0]   best_r, best_nxt_s;

    logic               out_valid_r;
    logic [WIDTH-1:0]   result_r, res_nxt_s;
    logic [2:0]         flags_r, flags_nxt_s;
    logic [CNT_W-1:0]   count_r, count_nxt_s;
    logic [CNT_W-1:0]   win_idx_r, win_nxt_s;

    logic in_ready_s, accept_s, run_mode_s, produce_s, upd_s;
    logic x_gt_y_s, x_lt_y_s, x_eq_y_s;

    assign in_ready_s = !out_valid_r || out_ready;
    assign accept_s   = in_valid && in_ready_s;
    assign run_mode_s = (mode == MODE_RMAX) || (mode == MODE_RMIN);
    assign x_gt_y_s   = ord_gt(x, y);
    assign x_lt_y_s   = ord_gt(y, x);
    assign x_eq_y_s   = (x == y);
    // Strict compare keeps the earliest index on ties.
    assign upd_s      = seq_min_r ? ord_gt(acc_r, x) : ord_gt(x, acc_r);

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign flags     = flags_r;
    assign count     = count_r;
    assign win_idx   = win_idx_r;

    // Next-state logic for the running-sequence FSM.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && run_mode_s && !last) begin
                    state_nxt_s = ST_ACCUM;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (accept_s && last) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_ACCUM;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Datapath and output-register next values for the accepted beat.
    always_comb begin
        produce_s     = 1'b0;
        res_nxt_s     = {WIDTH{1'b0}};
        flags_nxt_s   = 3'b000;
        count_nxt_s   = CNT_ONE;
        win_nxt_s     = {CNT_W{1'b0}};
        acc_nxt_s     = acc_r;
        cnt_nxt_s     = cnt_r;
        best_nxt_s    = best_r;
        seq_min_nxt_s = seq_min_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && run_mode_s) begin
                    seq_min_nxt_s = (mode == MODE_RMIN);
                    acc_nxt_s     = x;
                    cnt_nxt_s     = CNT_ONE;
                    best_nxt_s    = {CNT_W{1'b0}};
                    if (last) begin
                        produce_s = 1'b1;
                        res_nxt_s = x;
                    end else begin
                        produce_s = 1'b0;
                    end
                end else if (accept_s) begin
                    produce_s   = 1'b1;
                    flags_nxt_s = {x_eq_y_s, x_gt_y_s, x_lt_y_s};
                    case (mode)
                        MODE_EQ:  res_nxt_s = {{(WIDTH-1){1'b0}}, x_eq_y_s};
                        MODE_GT:  res_nxt_s = {{(WIDTH-1){1'b0}}, x_gt_y_s};
                        MODE_LT:  res_nxt_s = {{(WIDTH-1){1'b0}}, x_lt_y_s};
                        MODE_MAX: res_nxt_s = x_lt_y_s ? y : x;
                        MODE_MIN: res_nxt_s = x_gt_y_s ? y : x;
                        default: begin
                            res_nxt_s   = {WIDTH{1'b0}};
                            flags_nxt_s = 3'b000;
                        end
                    endcase
                end else begin
                    produce_s = 1'b0;
                end
            end
            ST_ACCUM: begin
                if (accept_s) begin
                    acc_nxt_s  = upd_s ? x : acc_r;
                    best_nxt_s = upd_s ? cnt_r : best_r;
                    cnt_nxt_s  = sat_inc(cnt_r);
                    if (last) begin
                        produce_s   = 1'b1;
                        res_nxt_s   = acc_nxt_s;
                        count_nxt_s = cnt_nxt_s;
                        win_nxt_s   = best_nxt_s;
                    end else begin
                        produce_s = 1'b0;
                    end
                end else begin
                    produce_s = 1'b0;
                end
            end
            default: produce_s = 1'b0;
        endcase
    end

    // State, sequence accumulator and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            seq_min_r   <= 1'b0;
            acc_r       <= {WIDTH{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            best_r      <= {CNT_W{1'b0}};
            out_valid_r <= 1'b0;
            result_r    <= {WIDTH{1'b0}};
            flags_r     <= 3'b000;
            count_r     <= {CNT_W{1'b0}};
            win_idx_r   <= {CNT_W{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            seq_min_r <= seq_min_nxt_s;
            acc_r     <= acc_nxt_s;
            cnt_r     <= cnt_nxt_s;
            best_r    <= best_nxt_s;
            if (produce_s) begin
                out_valid_r <= 1'b1;
                result_r    <= res_nxt_s;
                flags_r     <= flags_nxt_s;
                count_r     <= count_nxt_s;
                win_idx_r   <= win_nxt_s;
            end else if (out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

endmodule

// File: doc/seq_compare_unit.md
Name: seq_compare_unit

Overview:
Registered, parametrised comparison engine, successor to the combinational 4-bit compare block. Accepts operand pairs over a valid/ready stream and returns pairwise results (EQ/GT/LT/MAX/MIN) or running extremum results (RUN_MAX/RUN_MIN) over a framed sequence. Sits between the operand source and the display/result mux in the datapath.

Parameters:
WIDTH, 4, operand and result width in bits (>=2)
SIGNED, 0, 0 = unsigned compare, 1 = two's-complement compare
CNT_W, 8, width of beat counter and winner index

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  operand beat valid
in_ready  out  1  unit can accept a beat
x  in  WIDTH  operand X; the stream operand in running modes
y  in  WIDTH  operand Y; ignored in running modes
mode  in  3  0 EQ, 1 GT, 2 LT, 3 MAX, 4 MIN, 5 RUN_MAX, 6 RUN_MIN, 7 reserved
last  in  1  marks the final beat of a running sequence; ignored in pairwise modes
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
result  out  WIDTH  EQ/GT/LT: bit0 = flag, upper bits 0; MAX/MIN/RUN_*: selected value
flags  out  3  {eq, gt, lt} of the X-vs-Y compare for the accepted beat; 0 in running modes
count  out  CNT_W  running: number of beats in the sequence (saturating); pairwise: 1
win_idx  out  CNT_W  running: 0-based index of the winning beat; pairwise: 0

Behaviour:
- Handshake: beat accepted when in_valid && in_ready. Result transfers when out_valid && out_ready. in_ready = !out_valid || out_ready, so one output register is kept and throughput is 1/cycle when the consumer is always ready.
- Reset (rst=1 at clk edge): out_valid=0, result=0, flags=0, count=0, win_idx=0, acc=0, beat counter=0, state=IDLE. A sequence in progress is discarded. in_ready=1 the cycle after reset.
- Compare: with SIGNED=1, operands are compared as two's complement. Otherwise they are compared as unsigned.
- Pairwise modes 0-4: latency 1. Output registers load on the accepted beat, and out_valid=1 the next cycle. MAX ties return x and MIN ties return x. Mode 7 produces result=0, flags=0, count=1.
- State machine for running modes:
  - IDLE: an accepted beat with mode 5/6 latches the mode into seq_mode, sets acc=x, beat counter=1, best=0.
    - If last=1 on that beat, the result is emitted immediately with count=1, win_idx=0, and the state stays IDLE.
    - Otherwise the state moves to ACCUM.
  - ACCUM: each accepted beat updates acc using strict compare (RUN_MAX: x>acc; RUN_MIN: x<acc). On update, best=current index. Ties keep the earliest index. The beat counter increments and saturates at 2^CNT_W-1. The index also saturates.
  - ACCUM, last=1: the output is loaded with result=updated acc, count, win_idx. The state returns to IDLE.
  - ACCUM, non-last beats: no output is produced, and in_ready tracks the output register only.
  - The mode input is ignored while in ACCUM, because seq_mode governs the sequence. A pairwise-mode beat cannot interleave a running sequence.
- Output holds stable while out_valid && !out_ready. Output registers load only on a beat that produces a result.
- Simultaneous out_ready and a new producing beat: the old result is consumed and the new one loads the same edge, so out_valid stays 1.
- Reset asserted together with in_valid: reset wins and the beat is dropped.

Test Plan:
- WIDTH=4 unsigned, mode EQ x=5 y=5 -> next cycle out_valid=1, result=0001, flags=100. Mode GT x=9 y=3 -> result=0001, flags=010.
- WIDTH=4 SIGNED=1, mode MAX x=4'hF(-1) y=4'h2 -> result=4'h2, flags=001. Same operands with SIGNED=0 -> result=4'hF, flags=010.
- RUN_MAX sequence x=3,7,2,7(last) -> one result: result=7, count=4, win_idx=1, no out_valid before the last beat.
- out_ready=0 for 3 cycles during pairwise stream -> in_ready=0 after the first result, result held. Release -> back-to-back results with out_valid continuously 1 and no beat lost.
- RUN_MIN x=6,1 then rst=1 mid-sequence, then RUN_MIN x=4(last) -> result=4, count=1, win_idx=0. The aborted sequence produces no output.
- CNT_W=2, RUN_MAX with 5 beats, maximum value on beat 4 -> count=3 (saturated), win_idx=3.
